tl_state_hold: RTL

- Parametrised successor to the fixed 2-bit current-state register of the traffic-light controller.
- Holds the current state `q` and a per-state dwell down-counter.
- Accepts a new state from ns_logic only when the current state's dwell has expired. An override input `force` loads immediately, for emergency or pedestrian preemption.
- Sits between ns_logic and the output logic. It replaces the bare state register and the separate timer.

---
 rtl/tl_pkg.sv | 20 ++
 rtl/tl_state_hold_register_r_async_en.sv | 24 ++
 rtl/tl_state_hold.sv | 90 +++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// Shared traffic-light definitions: state encodings, default widths and
// nominal dwell lengths used by the controller and its state-hold stage.
package tl_pkg;

  localparam int TL_SW = 2;
  localparam int TL_CW = 8;

  typedef enum logic [1:0] {
    S_GREEN  = 2'b00,
    S_YELLOW = 2'b01,
    S_RED    = 2'b10,
    S_FLASH  = 2'b11
  } tl_state_e;

  // Nominal dwell lengths in clock cycles for each lit phase.
  localparam logic [TL_CW-1:0] D_GREEN  = 8'd60;
  localparam logic [TL_CW-1:0] D_YELLOW = 8'd8;
  localparam logic [TL_CW-1:0] D_RED    = 8'd45;

endpackage

// File: rtl/tl_state_hold_register_r_async_en.sv
// Generic W-bit register with enable and asynchronous active-low reset to a
// parameterised value.
module tl_state_hold_register_r_async_en #(
  parameter int           W   = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Capture d when enabled; reset wins asynchronously.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= RST;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/tl_state_hold.sv
// Current-state register plus per-state dwell down-counter. ns_logic's request
// is only taken once the dwell has run out; force_load preempts at any time.
module tl_state_hold
  import tl_pkg::*;
#(
  parameter int            SW          = TL_SW,
  parameter int            CW          = TL_CW,
  parameter logic [SW-1:0] RESET_STATE = SW'(S_GREEN),
  parameter logic [CW-1:0] RESET_DWELL = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [SW-1:0] d,
  input  logic [CW-1:0] dwell,
  input  logic          load,
  input  logic          force_load,
  output logic [SW-1:0] q,
  output logic [CW-1:0] cnt,
  output logic          expire,
  output logic          changed,
  output logic          rejected
);

  logic          acc;
  logic          cnt_en;
  logic [CW-1:0] cnt_d;
  logic [1:0]    flags_d;
  logic [1:0]    flags_q;

  assign expire   = (cnt == '0);
  assign changed  = flags_q[1];
  assign rejected = flags_q[0];

  // Accept decision and next values for the counter and the pulse flags.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    acc     = 1'b0;
    cnt_en  = 1'b0;
    cnt_d   = cnt;
    flags_d = 2'b00;

    acc = force_load | (load & expire);

    if (acc) begin
      cnt_en  = 1'b1;
      cnt_d   = dwell;
      flags_d = {(d != q), 1'b0};
    end else begin
      // Count down and stick at zero rather than wrapping.
      cnt_en  = (cnt != '0);
      cnt_d   = cnt - CW'(1);
      flags_d = {1'b0, load};
    end
  end

  tl_state_hold_register_r_async_en #(
    .W   (SW),
    .RST (RESET_STATE)
  ) u_q_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (acc),
    .d       (d),
    .q       (q)
  );

  tl_state_hold_register_r_async_en #(
    .W   (CW),
    .RST (RESET_DWELL)
  ) u_cnt_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (cnt_en),
    .d       (cnt_d),
    .q       (cnt)
  );

  // Pulse flags are rewritten every cycle: {changed, rejected}.
  tl_state_hold_register_r_async_en #(
    .W   (2),
    .RST (2'b00)
  ) u_flag_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (1'b1),
    .d       (flags_d),
    .q       (flags_q)
  );

endmodule
